// File: rtl/leftshift_seq_32bit.sv
// Multi-cycle left shifter: shifts (or rotates) a WIDTH-bit operand one bit
// per clock behind valid/ready handshakes on both sides.
module leftshift_seq_32bit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               rotate,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   Result,
  output logic               carry_out,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_reg;
  logic [WIDTH-1:0]   work_reg;
  logic [SHAMT_W-1:0] count_reg;
  logic               mode_reg;
  logic               carry_reg;
  logic               in_ready_reg;
  logic               out_valid_reg;
  logic               busy_reg;

  // Status flags are registered alongside the state so every output comes
  // straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      work_reg      <= '0;
      count_reg     <= '0;
      mode_reg      <= 1'b0;
      carry_reg     <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            work_reg     <= A;
            count_reg    <= shamt;
            mode_reg     <= rotate;
            carry_reg    <= 1'b0;
            in_ready_reg <= 1'b0;
            if (shamt == '0) begin
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
            end else begin
              state_reg <= SHIFT;
              busy_reg  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          // Rotate re-inserts the outgoing MSB; logical mode fills with zero.
          carry_reg <= work_reg[WIDTH-1];
          work_reg  <= {work_reg[WIDTH-2:0], mode_reg & work_reg[WIDTH-1]};
          count_reg <= count_reg - 1'b1;
          if (count_reg == SHAMT_W'(1)) begin
            state_reg     <= DONE;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign Result    = work_reg;
  assign carry_out = carry_reg;

endmodule

// File: tb/tb_leftshift_seq_32bit.sv
// Randomized self-checking bench for leftshift_seq_32bit against an
// arithmetic shift/rotate reference model.
module tb_leftshift_seq_32bit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [4:0]  shamt;
  logic        rotate;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        carry_out;
  logic        busy;

  int total = 0;
  int bad   = 0;

  leftshift_seq_32bit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .shamt     (shamt),
    .rotate    (rotate),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (result),
    .carry_out (carry_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: a 64-bit product of the operand and 2**sh holds the shifted
  // word in its low half and the bits pushed out in its high half.
  task automatic model(input logic [31:0] op, input int sh, input bit rot,
                       output logic [31:0] res, output logic cout);
    logic [63:0] wide;
    wide = 64'(op) * (64'd1 << sh);
    if (sh == 0) begin
      res  = op;
      cout = 1'b0;
    end else begin
      res  = rot ? (wide[31:0] | wide[63:32]) : wide[31:0];
      cout = wide[32];
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_result"},    result,         32'd0);
    check({tag, "_carry"},     32'(carry_out), 32'd0);
  endtask

  // One full transaction. stall = DONE cycles with out_ready low while a new
  // operand is offered; that operand must not be taken at the handshake edge.
  task automatic run_op(input logic [31:0] op, input int sh, input bit rot, input int stall);
    logic [31:0] exp_res;
    logic        exp_c;
    int          lat;
    int          busy_cnt;
    model(op, sh, rot, exp_res, exp_c);
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    a         = op;
    shamt     = 5'(sh);
    rotate    = rot;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    a        = $urandom;
    shamt    = 5'($urandom);
    rotate   = 1'($urandom);
    lat      = 0;
    busy_cnt = 0;
    while (!out_valid && lat < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    check("latency",   32'(lat),       32'(sh));
    check("busy_cyc",  32'(busy_cnt),  32'(sh));
    check("result",    result,         exp_res);
    check("carry",     32'(carry_out), 32'(exp_c));
    check("done_rdy",  32'(in_ready),  32'd0);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      a        = $urandom;
      shamt    = 5'($urandom);
      @(negedge clk);
      check("stall_valid",  32'(out_valid), 32'd1);
      check("stall_result", result,         exp_res);
      check("stall_carry",  32'(carry_out), 32'(exp_c));
      check("stall_rdy",    32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("post_valid",  32'(out_valid), 32'd0);
    check("post_rdy",    32'(in_ready),  32'd1);
    check("post_busy",   32'(busy),      32'd0);
    check("post_result", result,         exp_res);
    $display("op A=%h shamt=%0d rot=%0d -> Result=%h carry=%0d lat=%0d stall=%0d",
             op, sh, rot, result, carry_out, lat, stall);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    shamt     = '0;
    rotate    = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_rel");

    run_op(32'h8000_0001, 1,  1'b0, 0);
    run_op(32'h1234_5678, 8,  1'b1, 0);
    run_op(32'hDEAD_BEEF, 0,  1'b0, 0);
    run_op(32'hFFFF_FFFF, 31, 1'b0, 0);
    run_op(32'h8765_4321, 31, 1'b1, 2);
    run_op(32'hCAFE_F00D, 3,  1'b1, 5);

    // Reset pulled low mid-cycle during the fifth SHIFT cycle.
    @(negedge clk);
    in_valid = 1'b1;
    a        = 32'hA5A5_A5A5;
    shamt    = 5'd20;
    rotate   = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("midop_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    repeat (2) @(negedge clk);
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    run_op(32'h0000_0001, 4, 1'b0, 0);

    for (int n = 0; n < 30; n++) begin
      run_op($urandom, int'($urandom_range(0, 31)), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
